// File: rtl/core_mem_arb_pkg.sv
// Shared constants and sizing helpers for the N-hart memory-port arbiter.
package core_mem_arb_pkg;

    // Bus field widths on both the hart side and the memory side
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Channel selectors, used to index the per-channel arrays in the top level
    localparam int NUM_CH  = 2;
    localparam int CH_INST = 0;
    localparam int CH_DATA = 1;

    // Hart tag width: clog2 of the hart count, but never narrower than one bit
    function automatic int id_width(input int harts);
        return (harts > 1) ? $clog2(harts) : 1;
    endfunction

    // Tag FIFO pointer width for a power-of-two depth
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_channel.sv
// One arbitration channel: round-robin grant over the hart requests plus an
// in-order tag FIFO that remembers which hart issued each outstanding read.
module mem_arb_channel
    import core_mem_arb_pkg::*;
#(
    parameter int HART_NUMS   = 2,
    parameter int OUTSTANDING = 4,
    parameter int ID_W        = id_width(HART_NUMS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [HART_NUMS-1:0] req,
    input  logic [HART_NUMS-1:0] rd,
    input  logic                 mem_wait,
    input  logic                 rsp_valid,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 issue,
    output logic                 accept,
    output logic                 pop,
    output logic [ID_W-1:0]      head_id,
    output logic                 err
);

    localparam int PTR_W = ptr_width(OUTSTANDING);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  tag_mem [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             grant_rd;
    logic             blocked;
    logic             push;

    // Round-robin search: the lowest offset from rr_ptr with a request wins
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = HART_NUMS - 1; k >= 0; k--) begin
            if (rst_n && req[(int'(rr_ptr) + k) % HART_NUMS]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'((int'(rr_ptr) + k) % HART_NUMS);
            end
        end
    end

    // Whether the granted request carries a read that needs a tag
    always_comb begin
        grant_rd = 1'b0;
        for (int i = 0; i < HART_NUMS; i++) begin
            if (grant_valid && grant_id == ID_W'(i)) begin
                grant_rd = rd[i];
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(OUTSTANDING));
    // A response only routes when a tag is waiting; responses during reset are ignored
    assign pop     = rst_n & rsp_valid & ~empty;
    // A full FIFO only blocks a read if no slot frees up this same cycle
    assign blocked = grant_rd & full & ~pop;
    // Memory-side enable: granted and not held back by the tag FIFO
    assign issue   = grant_valid & ~blocked;
    assign accept  = issue & ~mem_wait;
    assign push    = accept & grant_rd;
    assign head_id = tag_mem[rd_ptr];

    // Arbiter pointer, FIFO pointers/occupancy and sticky error flag
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (int'(grant_id) == HART_NUMS - 1) ? '0 : grant_id + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (rsp_valid && empty) begin
                err <= 1'b1;
            end
        end
    end

    // Tag storage write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; entries are only read behind the reset-cleared occupancy count.
        if (push) begin
            tag_mem[wr_ptr] <= grant_id;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges HART_NUMS core instruction/data memory interfaces onto one physical
// memory port. Each channel arbitrates independently; read responses are
// routed back to their issuing hart in order.
module core_mem_arbiter
    import core_mem_arb_pkg::*;
#(
    parameter int HART_NUMS   = 2,
    parameter int OUTSTANDING = 4,
    parameter int ID_W        = id_width(HART_NUMS)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [HART_NUMS-1:0]          H_INST_RDEN,
    input  logic [HART_NUMS*DATA_W-1:0]   H_INST_RIADDR,
    output logic [HART_NUMS*DATA_W-1:0]   H_INST_ROADDR,
    output logic [HART_NUMS-1:0]          H_INST_RVALID,
    output logic [HART_NUMS*DATA_W-1:0]   H_INST_RDATA,
    input  logic [HART_NUMS-1:0]          H_DATA_RDEN,
    input  logic [HART_NUMS*DATA_W-1:0]   H_DATA_RIADDR,
    output logic [HART_NUMS*DATA_W-1:0]   H_DATA_ROADDR,
    output logic [HART_NUMS-1:0]          H_DATA_RVALID,
    output logic [HART_NUMS*DATA_W-1:0]   H_DATA_RDATA,
    input  logic [HART_NUMS-1:0]          H_DATA_WREN,
    input  logic [HART_NUMS*STRB_W-1:0]   H_DATA_WSTRB,
    input  logic [HART_NUMS*DATA_W-1:0]   H_DATA_WADDR,
    input  logic [HART_NUMS*DATA_W-1:0]   H_DATA_WDATA,
    output logic [HART_NUMS-1:0]          H_MEM_WAIT,
    output logic                          INST_RDEN,
    output logic [DATA_W-1:0]             INST_RIADDR,
    input  logic [DATA_W-1:0]             INST_ROADDR,
    input  logic                          INST_RVALID,
    input  logic [DATA_W-1:0]             INST_RDATA,
    output logic                          DATA_RDEN,
    output logic [DATA_W-1:0]             DATA_RIADDR,
    input  logic [DATA_W-1:0]             DATA_ROADDR,
    input  logic                          DATA_RVALID,
    input  logic [DATA_W-1:0]             DATA_RDATA,
    output logic                          DATA_WREN,
    output logic [STRB_W-1:0]             DATA_WSTRB,
    output logic [DATA_W-1:0]             DATA_WADDR,
    output logic [DATA_W-1:0]             DATA_WDATA,
    input  logic                          MEM_WAIT,
    output logic                          ERR
);

    logic [HART_NUMS-1:0] ch_req [NUM_CH];
    logic [HART_NUMS-1:0] ch_rd  [NUM_CH];
    logic [ID_W-1:0]      ch_grant [NUM_CH];
    logic [ID_W-1:0]      ch_head  [NUM_CH];
    logic [NUM_CH-1:0]    ch_rsp_valid;
    logic [NUM_CH-1:0]    ch_grant_valid;
    logic [NUM_CH-1:0]    ch_issue;
    logic [NUM_CH-1:0]    ch_accept;
    logic [NUM_CH-1:0]    ch_pop;
    logic [NUM_CH-1:0]    ch_err;

    // A data request covers both a read and a write; they travel together
    assign ch_req[CH_INST]       = H_INST_RDEN;
    assign ch_rd[CH_INST]        = H_INST_RDEN;
    assign ch_rsp_valid[CH_INST] = INST_RVALID;
    assign ch_req[CH_DATA]       = H_DATA_RDEN | H_DATA_WREN;
    assign ch_rd[CH_DATA]        = H_DATA_RDEN;
    assign ch_rsp_valid[CH_DATA] = DATA_RVALID;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mem_arb_channel #(
            .HART_NUMS   (HART_NUMS),
            .OUTSTANDING (OUTSTANDING),
            .ID_W        (ID_W)
        ) u_chan (
            .clk         (CLK),
            .rst_n       (RST),
            .req         (ch_req[c]),
            .rd          (ch_rd[c]),
            .mem_wait    (MEM_WAIT),
            .rsp_valid   (ch_rsp_valid[c]),
            .grant_valid (ch_grant_valid[c]),
            .grant_id    (ch_grant[c]),
            .issue       (ch_issue[c]),
            .accept      (ch_accept[c]),
            .pop         (ch_pop[c]),
            .head_id     (ch_head[c]),
            .err         (ch_err[c])
        );
    end

    // Forward the granted hart's fields to the memory port; all zero when idle
    always_comb begin
        INST_RDEN   = ch_issue[CH_INST];
        INST_RIADDR = '0;
        DATA_RDEN   = 1'b0;
        DATA_RIADDR = '0;
        DATA_WREN   = 1'b0;
        DATA_WSTRB  = '0;
        DATA_WADDR  = '0;
        DATA_WDATA  = '0;
        for (int i = 0; i < HART_NUMS; i++) begin
            if (ch_grant_valid[CH_INST] && ch_grant[CH_INST] == ID_W'(i)) begin
                INST_RIADDR = H_INST_RIADDR[i*DATA_W +: DATA_W];
            end
            if (ch_grant_valid[CH_DATA] && ch_grant[CH_DATA] == ID_W'(i)) begin
                DATA_RDEN   = ch_issue[CH_DATA] & H_DATA_RDEN[i];
                DATA_RIADDR = H_DATA_RIADDR[i*DATA_W +: DATA_W];
                DATA_WREN   = ch_issue[CH_DATA] & H_DATA_WREN[i];
                DATA_WSTRB  = H_DATA_WSTRB[i*STRB_W +: STRB_W];
                DATA_WADDR  = H_DATA_WADDR[i*DATA_W +: DATA_W];
                DATA_WDATA  = H_DATA_WDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Route response valids to the tagged hart and combine per-hart stalls
    always_comb begin
        H_INST_RVALID = '0;
        H_DATA_RVALID = '0;
        H_MEM_WAIT    = '0;
        for (int i = 0; i < HART_NUMS; i++) begin
            H_INST_RVALID[i] = ch_pop[CH_INST] && (ch_head[CH_INST] == ID_W'(i));
            H_DATA_RVALID[i] = ch_pop[CH_DATA] && (ch_head[CH_DATA] == ID_W'(i));
            H_MEM_WAIT[i]    = !RST || MEM_WAIT
                || (ch_req[CH_INST][i] && !(ch_accept[CH_INST] && ch_grant[CH_INST] == ID_W'(i)))
                || (ch_req[CH_DATA][i] && !(ch_accept[CH_DATA] && ch_grant[CH_DATA] == ID_W'(i)));
        end
    end

    // Response address/data fan out to every hart; only RVALID is steered
    assign H_INST_ROADDR = {HART_NUMS{INST_ROADDR}};
    assign H_INST_RDATA  = {HART_NUMS{INST_RDATA}};
    assign H_DATA_ROADDR = {HART_NUMS{DATA_ROADDR}};
    assign H_DATA_RDATA  = {HART_NUMS{DATA_RDATA}};
    assign ERR           = |ch_err;

endmodule
